// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath glue.
package router_pkg;
  localparam int NUM_CH          = 3;
  localparam int ADDR_W          = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
  localparam int TIMEOUT_DEFAULT = 30;
endpackage

// File: rtl/router_sync_timer.sv
// Per-channel read watchdog: one-cycle soft_reset after TIMEOUT undrained edges.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Counter restarts on the firing edge, so a FIFO still clearing cannot re-trigger.
  always_ff @(posedge clk) begin
    if (reset || !vld || read_enb) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end
endmodule

// File: rtl/router_sync.sv
// Header address latch, write steering and per-channel timeout for the 1x3 router.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic              read_enb_0,
  input  logic              read_enb_1,
  input  logic              read_enb_2,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              full_0,
  input  logic              full_1,
  input  logic              full_2,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              vld_out_0,
  output logic              vld_out_1,
  output logic              vld_out_2,
  output logic              soft_reset_0,
  output logic              soft_reset_1,
  output logic              soft_reset_2
);
  logic [ADDR_W-1:0] addr;
  logic [NUM_CH-1:0] vld_v, rd_v, sr_v;

  // A header and a write in the same cycle still use the previous address.
  always_ff @(posedge clk) begin
    if (reset)           addr <= ADDR_INVALID;
    else if (detect_add) addr <= data_in;
  end

  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    case (addr)
      2'd0: begin write_enb = {2'b00, write_enb_reg};        fifo_full = full_0; end
      2'd1: begin write_enb = {1'b0, write_enb_reg, 1'b0};   fifo_full = full_1; end
      2'd2: begin write_enb = {write_enb_reg, 2'b00};        fifo_full = full_2; end
      default: ;
    endcase
  end

  assign vld_v = {~empty_2, ~empty_1, ~empty_0};
  assign rd_v  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0    = vld_v[0];
  assign vld_out_1    = vld_v[1];
  assign vld_out_2    = vld_v[2];
  assign soft_reset_0 = sr_v[0];
  assign soft_reset_1 = sr_v[1];
  assign soft_reset_2 = sr_v[2];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmr (
      .clk       (clk),
      .reset     (reset),
      .vld       (vld_v[i]),
      .read_enb  (rd_v[i]),
      .soft_reset(sr_v[i])
    );
  end
endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: steering, full mux, timeout pulses, reset.
module tb_router_sync;
  logic       clk = 1'b0;
  logic       reset, detect_add, write_enb_reg;
  logic [1:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int checks = 0;
  int errors = 0;

  router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b0; empty_2 = 1'b1;
    full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
    @(negedge clk);
    step(); step();
    chk("rst_write_enb", 32'(write_enb), 32'h0);
    chk("rst_fifo_full", 32'(fifo_full), 32'h0);
    chk("rst_soft_reset", 32'({soft_reset_2, soft_reset_1, soft_reset_0}), 32'h0);
    chk("rst_vld_out", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'b010);
    empty_0 = 1'b0; empty_1 = 1'b1; empty_2 = 1'b0; #1;
    chk("vld_out_mirror", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'b101);

    // Address steering to channel 1
    reset = 1'b0; empty_0 = 1'b1; empty_2 = 1'b1;
    write_enb_reg = 1'b0; full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    detect_add = 1'b1; data_in = 2'b01;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; #1;
    chk("steer1_write_enb", 32'(write_enb), 32'b010);
    chk("steer1_full_lo", 32'(fifo_full), 32'h0);
    full_1 = 1'b1; #1;
    chk("steer1_full_hi", 32'(fifo_full), 32'h1);
    full_1 = 1'b0; full_0 = 1'b1; #1;
    chk("steer1_other_full", 32'(fifo_full), 32'h0);
    write_enb_reg = 1'b0; #1;
    chk("steer1_no_req", 32'(write_enb), 32'h0);

    // Invalid address never writes and masks full
    detect_add = 1'b1; data_in = 2'b11;
    step();
    detect_add = 1'b0; write_enb_reg = 1'b1; full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1; #1;
    chk("inv_write_enb", 32'(write_enb), 32'h0);
    chk("inv_fifo_full", 32'(fifo_full), 32'h0);
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

    // Same-cycle detect_add uses old address
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'b10;
    step();
    detect_add = 1'b1; data_in = 2'b00; write_enb_reg = 1'b1; full_2 = 1'b1; #1;
    chk("same_cyc_old", 32'(write_enb), 32'b100);
    chk("same_cyc_full", 32'(fifo_full), 32'h1);
    step();
    detect_add = 1'b0; #1;
    chk("same_cyc_new", 32'(write_enb), 32'b001);
    chk("same_cyc_new_full", 32'(fifo_full), 32'h0);
    full_2 = 1'b0;

    // Reset mid-packet returns to the invalid address
    reset = 1'b1;
    step();
    reset = 1'b0; #1;
    chk("midpkt_rst_write_enb", 32'(write_enb), 32'h0);
    write_enb_reg = 1'b0;

    // Timeout on channel 0, stalled from E1
    empty_0 = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      step();
      chk($sformatf("to0_E%0d", k), 32'(soft_reset_0), 32'(k == 30));
    end
    empty_0 = 1'b1;
    step(); step();

    // One read at E20 defers the pulse to E50
    empty_0 = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      read_enb_0 = (k == 20);
      step();
      chk($sformatf("rd0_E%0d", k), 32'(soft_reset_0), 32'(k == 50));
    end
    read_enb_0 = 1'b0; empty_0 = 1'b1;
    step(); step();

    // Channels 0 and 2 stall together, channel 1 drains every cycle
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0; read_enb_1 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      chk($sformatf("ind_E%0d", k), 32'({soft_reset_2, soft_reset_1, soft_reset_0}),
          (k == 30) ? 32'b101 : 32'b000);
    end
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1; read_enb_1 = 1'b0;
    step(); step();

    // Reset at E15 clears the pending timeouts
    empty_0 = 1'b0; empty_2 = 1'b0;
    for (int k = 1; k <= 46; k++) begin
      reset = (k == 15);
      step();
      chk($sformatf("rstto_E%0d", k), 32'({soft_reset_2, soft_reset_0}),
          (k == 45) ? 32'b11 : 32'b00);
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
